// File: rtl/riscv_rf_wb_queue_pkg.sv
// Shared widths, the queued writeback entry type and the entry match helper
// used by the writeback queue and its FIFO.
package riscv_rf_wb_queue_pkg;

  localparam int THREAD_ADDR_WIDTH = 2;
  localparam int ADDR_WIDTH        = 5;
  localparam int DATA_WIDTH        = 32;
  localparam int WB_Q_DEPTH        = 4;

  typedef struct packed {
    logic [THREAD_ADDR_WIDTH-1:0] hart;
    logic [ADDR_WIDTH-1:0]        addr;
    logic [DATA_WIDTH-1:0]        data;
  } wb_entry_t;

  // True when an entry targets the given thread and register.
  function automatic logic entry_match(input wb_entry_t e,
                                       input logic [THREAD_ADDR_WIDTH-1:0] hart,
                                       input logic [ADDR_WIDTH-1:0] addr);
    return (e.hart == hart) && (e.addr == addr);
  endfunction

endpackage

// File: rtl/riscv_rf_wb_queue_if.sv
// Late-result source handshakes and register-file write port A, bundled
// between the producers/RF (master side) and the writeback queue (slave side).
interface riscv_rf_wb_queue_if;
  import riscv_rf_wb_queue_pkg::*;

  logic                         src0_valid_i;
  logic                         src0_ready_o;
  logic [THREAD_ADDR_WIDTH-1:0] src0_hart_i;
  logic [ADDR_WIDTH-1:0]        src0_addr_i;
  logic [DATA_WIDTH-1:0]        src0_data_i;

  logic                         src1_valid_i;
  logic                         src1_ready_o;
  logic [THREAD_ADDR_WIDTH-1:0] src1_hart_i;
  logic [ADDR_WIDTH-1:0]        src1_addr_i;
  logic [DATA_WIDTH-1:0]        src1_data_i;

  logic                         port_a_block_i;
  logic                         we_a_o;
  logic [ADDR_WIDTH-1:0]        waddr_a_o;
  logic [DATA_WIDTH-1:0]        wdata_a_o;
  logic [THREAD_ADDR_WIDTH-1:0] hart_id_wb_o;

  modport slave (
    input  src0_valid_i, src0_hart_i, src0_addr_i, src0_data_i,
    input  src1_valid_i, src1_hart_i, src1_addr_i, src1_data_i,
    input  port_a_block_i,
    output src0_ready_o, src1_ready_o,
    output we_a_o, waddr_a_o, wdata_a_o, hart_id_wb_o
  );

  modport master (
    output src0_valid_i, src0_hart_i, src0_addr_i, src0_data_i,
    output src1_valid_i, src1_hart_i, src1_addr_i, src1_data_i,
    output port_a_block_i,
    input  src0_ready_o, src1_ready_o,
    input  we_a_o, waddr_a_o, wdata_a_o, hart_id_wb_o
  );

endinterface

// File: rtl/riscv_rf_wb_queue_fifo.sv
// Synchronous FIFO of writeback entries; exposes head, head+1 and every slot
// with a valid mask so the owner can search all queued destinations at once.
module riscv_rf_wb_queue_fifo
  import riscv_rf_wb_queue_pkg::*;
#(
  parameter  int DEPTH = WB_Q_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  wb_entry_t        i_data,
  input  logic             i_pop,
  output wb_entry_t        o_head,
  output wb_entry_t        o_next,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output wb_entry_t        o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_rd_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; slots are only observed through the valid mask.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign w_rd_next = r_rd_ptr + 1'b1;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_next    = r_mem[w_rd_next];
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_entries = r_mem;

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    logic [PTR_W-1:0] w_off;
    assign w_off      = PTR_W'(g) - r_rd_ptr;
    assign o_valid[g] = (CNT_W'(w_off) < r_count);
  end

endmodule

// File: rtl/riscv_rf_wb_queue.sv
// Writeback queue driving RF port A: arbitrates LSU and mult/div results, drops
// x0 writes, drains one entry per cycle and reports pending rd hits to ID.
module riscv_rf_wb_queue
  import riscv_rf_wb_queue_pkg::*;
#(
  parameter  int DEPTH = WB_Q_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  riscv_rf_wb_queue_if.slave           wb_if,
  input  logic [THREAD_ADDR_WIDTH-1:0] q_hart_i,
  input  logic [3*ADDR_WIDTH-1:0]      q_addr_i,
  output logic [2:0]                   pending_o,
  output logic [CNT_W-1:0]             count_o
);

  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  wb_entry_t        w_head;
  wb_entry_t        w_next;
  wb_entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;

  logic             w_acc0;
  logic             w_acc1;
  wb_entry_t        w_in;
  logic             w_push;
  logic             w_fire;

  logic             r_we;
  wb_entry_t        r_out;

  assign wb_if.src0_ready_o = !w_full;
  assign wb_if.src1_ready_o = !w_full && !wb_if.src0_valid_i;
  assign w_acc0 = wb_if.src0_valid_i && wb_if.src0_ready_o;
  assign w_acc1 = wb_if.src1_valid_i && wb_if.src1_ready_o;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_in = '{hart: wb_if.src1_hart_i, addr: wb_if.src1_addr_i, data: wb_if.src1_data_i};
    if (w_acc0) begin
      w_in = '{hart: wb_if.src0_hart_i, addr: wb_if.src0_addr_i, data: wb_if.src0_data_i};
    end
  end

  // x0 results complete the handshake but never occupy a slot.
  assign w_push = (w_acc0 || w_acc1) && (w_in.addr != '0);
  assign w_fire = r_we && !wb_if.port_a_block_i && !rst;

  riscv_rf_wb_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (w_in),
    .i_pop     (w_fire),
    .o_head    (w_head),
    .o_next    (w_next),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  // The output register mirrors the head; the head is popped only when its
  // write actually happens, and the successor is staged in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we  <= 1'b0;
      r_out <= '0;
    end else if (w_fire) begin
      if (w_count >= CNT_W'(2)) begin
        r_we  <= 1'b1;
        r_out <= w_next;
      end else begin
        r_we  <= 1'b0;
      end
    end else if (!r_we && !w_empty && !wb_if.port_a_block_i) begin
      r_we  <= 1'b1;
      r_out <= w_head;
    end
  end

  assign wb_if.we_a_o       = w_fire;
  assign wb_if.waddr_a_o    = r_out.addr;
  assign wb_if.wdata_a_o    = r_out.data;
  assign wb_if.hart_id_wb_o = r_out.hart;
  assign count_o            = w_count;

  for (genvar k = 0; k < 3; k++) begin : g_pend
    logic [ADDR_WIDTH-1:0] w_qa;
    logic [DEPTH-1:0]      w_ent_hit;
    assign w_qa = q_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      assign w_ent_hit[e] = w_valid[e] && entry_match(w_entries[e], q_hart_i, w_qa);
    end
    assign pending_o[k] = (w_qa != '0) &&
                          ((|w_ent_hit) ||
                           (r_we && entry_match(r_out, q_hart_i, w_qa)) ||
                           (w_push && entry_match(w_in, q_hart_i, w_qa)));
  end

endmodule
